// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter.
// Word-wide memory port shared by the instruction-side and data-side compressed caches.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } arb_state_t;

   localparam int unsigned DEF_BURST_LEN = 16;
   localparam int unsigned BURST_BITS    = $clog2(DEF_BURST_LEN);

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshake and main-memory port bundle for mem_port_arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface mem_port_arbiter_if #(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned WORD_WIDTH = 32
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_write;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*WORD_WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [WORD_WIDTH-1:0]         rsp_data;
   logic                          rsp_last;
   logic [ADDR_WIDTH-1:0]         memory_addr;
   logic                          memory_write_en;
   logic [WORD_WIDTH-1:0]         memory_write_data;
   logic                          memory_read_addr_valid;
   logic                          memory_read_ready;
   logic                          memory_read_valid;
   logic [WORD_WIDTH-1:0]         memory_read_data;
   logic                          protocol_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      output memory_read_ready, memory_read_valid, memory_read_data,
      input  req_ready, rsp_valid, rsp_data, rsp_last,
      input  memory_addr, memory_write_en, memory_write_data, memory_read_addr_valid,
      input  protocol_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      input  memory_read_ready, memory_read_valid, memory_read_data,
      output req_ready, rsp_valid, rsp_data, rsp_last,
      output memory_addr, memory_write_en, memory_write_data, memory_read_addr_valid,
      output protocol_err
   );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_grant_i+1 with wrap.
// Produces no grant while en_i is low.
module rr_arbiter #(
   parameter int unsigned NumReq = 2,
   localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic [NumReq-1:0] req_i,
   input  logic [IdxW-1:0]   last_grant_i,
   input  logic              en_i,
   output logic [NumReq-1:0] grant_o,
   output logic [IdxW-1:0]   grant_idx_o
);

   int unsigned idx;
   logic        found;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      idx         = 0;
      for (int unsigned off = 1; off <= NumReq; off++) begin
         idx = (32'(last_grant_i) + off) % NumReq;
         if (en_i && !found && req_i[IdxW'(idx)]) begin
            found                 = 1'b1;
            grant_o[IdxW'(idx)]   = 1'b1;
            grant_idx_o           = IdxW'(idx);
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the shared word-wide memory port: single writes or aligned burst reads,
// with the port locked for the whole transaction and returned words steered to the owner.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned BURST_LEN  = DEF_BURST_LEN
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.slave   bus
);

   localparam int unsigned BurstBits = $clog2(BURST_LEN);
   localparam int unsigned CntW      = BurstBits + 1;
   localparam int unsigned IdxW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t             state_q, state_d;
   logic [IdxW-1:0]        last_grant_q, last_grant_d;
   logic [IdxW-1:0]        owner_q, owner_d;
   logic [ADDR_WIDTH-1:0]  base_q, base_d;
   logic [ADDR_WIDTH-1:0]  maddr_q, maddr_d;
   logic [WORD_WIDTH-1:0]  wdata_q, wdata_d;
   logic [CntW-1:0]        issue_cnt_q, issue_cnt_d;
   logic [CntW-1:0]        ret_cnt_q, ret_cnt_d;
   logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;
   logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
   logic [WORD_WIDTH-1:0]  rsp_data_q, rsp_data_d;
   logic                   rsp_last_q, rsp_last_d;
   logic                   we_q, we_d;
   logic                   rav_q, rav_d;
   logic                   perr_q, perr_d;

   logic [NUM_REQ-1:0]     grant;
   logic [IdxW-1:0]        grant_idx;
   logic [ADDR_WIDTH-1:0]  g_addr;
   logic [WORD_WIDTH-1:0]  g_wdata;
   logic                   g_write;

   rr_arbiter #(
      .NumReq (NUM_REQ)
   ) u_rr_arbiter (
      .req_i        (bus.req_valid),
      .last_grant_i (last_grant_q),
      .en_i         (state_q == IDLE),
      .grant_o      (grant),
      .grant_idx_o  (grant_idx)
   );

   // One-hot AND-OR select of the granted requester's fields.
   always_comb begin
      g_addr  = '0;
      g_wdata = '0;
      g_write = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant[k]) begin
            g_addr  = g_addr | bus.req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            g_wdata = g_wdata | bus.req_wdata[k*WORD_WIDTH +: WORD_WIDTH];
            g_write = g_write | bus.req_write[k];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      base_d       = base_q;
      maddr_d      = maddr_q;
      wdata_d      = wdata_q;
      issue_cnt_d  = issue_cnt_q;
      ret_cnt_d    = ret_cnt_q;
      req_ready_d  = '0;
      rsp_valid_d  = '0;
      rsp_data_d   = rsp_data_q;
      rsp_last_d   = 1'b0;
      we_d         = 1'b0;
      rav_d        = 1'b0;
      perr_d       = perr_q;

      unique case (state_q)
         IDLE: begin
            if (|grant) begin
               req_ready_d  = grant;
               last_grant_d = grant_idx;
               owner_d      = grant_idx;
               if (g_write) begin
                  maddr_d = g_addr;
                  wdata_d = g_wdata;
                  we_d    = 1'b1;
                  state_d = WRITE;
               end else begin
                  base_d      = g_addr & ~ADDR_WIDTH'(BURST_LEN - 1);
                  issue_cnt_d = '0;
                  ret_cnt_d   = '0;
                  state_d     = READ;
               end
            end
         end
         WRITE: state_d = IDLE;
         READ: begin
            // Issue and return sides advance independently.
            if (bus.memory_read_ready && (issue_cnt_q < CntW'(BURST_LEN))) begin
               maddr_d     = base_q | ADDR_WIDTH'(issue_cnt_q[BurstBits-1:0]);
               rav_d       = 1'b1;
               issue_cnt_d = issue_cnt_q + 1'b1;
            end
            if (bus.memory_read_valid) begin
               rsp_valid_d[owner_q] = 1'b1;
               rsp_data_d           = bus.memory_read_data;
               ret_cnt_d            = ret_cnt_q + 1'b1;
               if (ret_cnt_q == CntW'(BURST_LEN - 1)) begin
                  rsp_last_d = 1'b1;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (bus.memory_read_valid && (state_q != READ)) perr_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         last_grant_q <= IdxW'(NUM_REQ - 1);
         owner_q      <= '0;
         base_q       <= '0;
         maddr_q      <= '0;
         wdata_q      <= '0;
         issue_cnt_q  <= '0;
         ret_cnt_q    <= '0;
         req_ready_q  <= '0;
         rsp_valid_q  <= '0;
         rsp_data_q   <= '0;
         rsp_last_q   <= 1'b0;
         we_q         <= 1'b0;
         rav_q        <= 1'b0;
         perr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         base_q       <= base_d;
         maddr_q      <= maddr_d;
         wdata_q      <= wdata_d;
         issue_cnt_q  <= issue_cnt_d;
         ret_cnt_q    <= ret_cnt_d;
         req_ready_q  <= req_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_last_q   <= rsp_last_d;
         we_q         <= we_d;
         rav_q        <= rav_d;
         perr_q       <= perr_d;
      end
   end

   assign bus.req_ready              = req_ready_q;
   assign bus.rsp_valid              = rsp_valid_q;
   assign bus.rsp_data               = rsp_data_q;
   assign bus.rsp_last               = rsp_last_q;
   assign bus.memory_addr            = maddr_q;
   assign bus.memory_write_en        = we_q;
   assign bus.memory_write_data      = wdata_q;
   assign bus.memory_read_addr_valid = rav_q;
   assign bus.protocol_err           = perr_q;

endmodule
